// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg: shared RV32I load/store opcodes, funct3 codes and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes access size for both loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic ls_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (opcode == OPC_LOAD)
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    else if (opcode == OPC_STORE)
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if: core request/response and memory bus signals of mem_access.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, opcode, funct3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, opcode, funct3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align: byte-lane enables, store replication, alignment and load extension.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        aligned_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] w_shifted;

  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    aligned_o = (lane_i == 2'b00);
    case (size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << lane_i;
        wdata_o   = {4{wdata_i[7:0]}};
        aligned_o = 1'b1;
      end
      SZ_HALF: begin
        be_o      = 4'b0011 << lane_i;
        wdata_o   = {2{wdata_i[15:0]}};
        aligned_o = ~lane_i[0];
      end
      default: ;
    endcase
  end

  // funct3[2] marks the unsigned load variants
  always_comb begin
    w_shifted = rdata_i >> {ld_lane_i, 3'b000};
    ld_data_o = w_shifted;
    case (ld_funct3_i[1:0])
      SZ_BYTE: ld_data_o = ld_funct3_i[2] ? {24'd0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: ld_data_o = ld_funct3_i[2] ? {16'd0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access: RV32I load/store unit; IDLE/BUS/RESP FSM with bus timeout.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic          is_load_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [CW-1:0] tmo_q;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_aligned;
  logic [31:0]   w_ld_data;
  logic          w_accept_ok;

  mem_align u_align (
    .size_i      (bus.funct3[1:0]),
    .lane_i      (bus.addr[1:0]),
    .wdata_i     (bus.wdata),
    .be_o        (w_be),
    .wdata_o     (w_wdata),
    .aligned_o   (w_aligned),
    .ld_funct3_i (funct3_q),
    .ld_lane_i   (lane_q),
    .rdata_i     (bus.mem_rdata),
    .ld_data_o   (w_ld_data)
  );

  assign w_accept_ok = ls_legal(bus.opcode, bus.funct3) && w_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      lane_q       <= '0;
      tmo_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            is_load_q   <= (bus.opcode == OPC_LOAD);
            funct3_q    <= bus.funct3;
            lane_q      <= bus.addr[1:0];
            if (w_accept_ok) begin
              state_q     <= ST_BUS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (bus.opcode == OPC_STORE);
              mem_addr_q  <= {bus.addr[31:2], 2'b00};
              mem_be_q    <= w_be;
              mem_wdata_q <= w_wdata;
              tmo_q       <= '0;
            end else begin
              // Rejected requests never touch the bus
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus.mem_ack) begin
            state_q      <= ST_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            rdata_q      <= is_load_q ? w_ld_data : 32'd0;
          end else if (tmo_q == TMO_LAST) begin
            state_q      <= ST_RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access: directed self-checking bench for mem_access (TIMEOUT = 4).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;
  import mem_access_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Acks in the first BUS cycle and checks the response cycle and return to IDLE
  task automatic ack_load(input string tag, input logic [31:0] rd, input logic [31:0] exp);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack   = 1'b0;
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus.rdata, exp);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_mem_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk({tag, "_resp_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // LW, zero-wait ack
    issue(OPC_LOAD, F3_W, 32'h0000_0100, 32'h0);
    chk("lw_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("lw_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("lw_mem_addr", bus.mem_addr, 32'h0000_0100);
    chk("lw_mem_be", {28'd0, bus.mem_be}, 32'h0000_000f);
    chk("lw_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("lw_no_early_resp", {31'd0, bus.resp_valid}, 32'd0);
    ack_load("lw", 32'h8bad_f00d, 32'h8bad_f00d);
    chk("lw_rdata_hold", bus.rdata, 32'h8bad_f00d);

    // LB / LBU at lane 3
    issue(OPC_LOAD, F3_B, 32'h0000_0103, 32'h0);
    chk("lb_mem_be", {28'd0, bus.mem_be}, 32'h0000_0008);
    chk("lb_mem_addr", bus.mem_addr, 32'h0000_0100);
    ack_load("lb", 32'h8011_2233, 32'hffff_ff80);
    issue(OPC_LOAD, F3_BU, 32'h0000_0103, 32'h0);
    ack_load("lbu", 32'h8011_2233, 32'h0000_0080);

    // LH / LHU at lane 2
    issue(OPC_LOAD, F3_H, 32'h0000_0102, 32'h0);
    chk("lh_mem_be", {28'd0, bus.mem_be}, 32'h0000_000c);
    ack_load("lh", 32'h8011_2233, 32'hffff_8011);
    issue(OPC_LOAD, F3_HU, 32'h0000_0106, 32'h0);
    chk("lhu_mem_addr", bus.mem_addr, 32'h0000_0104);
    ack_load("lhu", 32'h8011_2233, 32'h0000_8011);

    // SH with a second request arriving during BUS that must be ignored
    issue(OPC_STORE, F3_H, 32'h0000_0202, 32'h0000_abcd);
    chk("sh_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("sh_mem_addr", bus.mem_addr, 32'h0000_0200);
    chk("sh_mem_be", {28'd0, bus.mem_be}, 32'h0000_000c);
    chk("sh_mem_wdata", bus.mem_wdata, 32'habcd_abcd);
    bus.req_valid = 1'b1;
    bus.opcode    = OPC_LOAD;
    bus.funct3    = F3_W;
    bus.addr      = 32'h0000_0900;
    tick();
    bus.req_valid = 1'b0;
    chk("sh_wait_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("sh_ignore_addr", bus.mem_addr, 32'h0000_0200);
    chk("sh_ignore_we", {31'd0, bus.mem_we}, 32'd1);
    ack_load("sh", 32'hdead_beef, 32'h0000_0000);

    // SB at lane 1
    issue(OPC_STORE, F3_B, 32'h0000_0301, 32'h1234_5678);
    chk("sb_mem_be", {28'd0, bus.mem_be}, 32'h0000_0002);
    chk("sb_mem_wdata", bus.mem_wdata, 32'h7878_7878);
    ack_load("sb", 32'h0, 32'h0);

    // Rejected requests: misaligned, illegal funct3, illegal opcode
    issue(OPC_LOAD, F3_W, 32'h0000_0101, 32'h0);
    chk("mis_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mis_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_err", {31'd0, bus.err}, 32'd1);
    chk("mis_rdata", bus.rdata, 32'd0);
    tick();
    chk("mis_err_hold", {31'd0, bus.err}, 32'd1);
    issue(OPC_LOAD, 3'b011, 32'h0000_0100, 32'h0);
    chk("f3_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("f3_err", {31'd0, bus.err}, 32'd1);
    chk("f3_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    issue(7'b0110011, F3_W, 32'h0000_0100, 32'h0);
    chk("opc_err", {31'd0, bus.err}, 32'd1);
    chk("opc_mem_req", {31'd0, bus.mem_req}, 32'd0);
    tick();

    // Stray ack in IDLE
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("idle_ack_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("idle_ack_ready", {31'd0, bus.req_ready}, 32'd1);

    // Timeout: mem_req held 4 cycles, then error response
    issue(OPC_LOAD, F3_W, 32'h0000_0400, 32'h0);
    chk("tmo_req_c1", {31'd0, bus.mem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_req_hold", {31'd0, bus.mem_req}, 32'd1);
      chk("tmo_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    tick();
    chk("tmo_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("tmo_err", {31'd0, bus.err}, 32'd1);
    chk("tmo_mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    tick();
    issue(OPC_LOAD, F3_W, 32'h0000_0500, 32'h0);
    chk("post_tmo_mem_req", {31'd0, bus.mem_req}, 32'd1);
    ack_load("post_tmo", 32'h1234_5678, 32'h1234_5678);

    // Reset in the middle of BUS
    issue(OPC_LOAD, F3_W, 32'h0000_0600, 32'h0);
    chk("rbus_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rbus_async_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rbus_async_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rbus_rdata_clr", bus.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rbus_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("rbus_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rbus_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("rbus_no_resp2", {31'd0, bus.resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
